mem_stage_lsu: RTL and testbench

Load/store unit for the memory (M) stage of the 5-stage RISC-V pipeline. It takes the address, store data and access controls held in the EX/MEM pipeline register and runs a single-outstanding req/ack transaction on the data-memory bus. It returns aligned, sign/zero-extended load data to the MEM/WB register. While a transaction is in flight it drives the pipeline stall that freezes the EX/MEM register and all upstream stages.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_dmem_if.sv | 22 ++
 rtl/lsu_align.sv | 51 +++++
 rtl/mem_stage_lsu.sv | 143 ++++++++++++++
 tb/tb_mem_stage_lsu.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the M-stage load/store unit.
// Holds the FSM state enum, access-kind and access-size encodings,
// and a helper that decides whether an access kind needs a bus cycle.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } lsu_state_e;

   // access kind (i_mem_wrenM); 2'b11 is reserved and behaves as none
   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_LOAD  = 2'b01;
   localparam logic [1:0] MEM_STORE = 2'b10;

   // access size (i_data_typeM); 2'b11 behaves as word
   localparam logic [1:0] DT_BYTE = 2'b00;
   localparam logic [1:0] DT_HALF = 2'b01;
   localparam logic [1:0] DT_WORD = 2'b10;

   function automatic logic is_access(input logic [1:0] kind);
      return (kind == MEM_LOAD) || (kind == MEM_STORE);
   endfunction

endpackage

// File: rtl/lsu_dmem_if.sv
// Data-memory bus between the LSU (master) and the memory (slave).
// Single outstanding req/ack: master holds req and the request fields
// until the slave returns ack (rdata valid in the ack cycle).
interface lsu_dmem_if;
   logic        o_dmem_req;
   logic        o_dmem_we;
   logic [31:0] o_dmem_addr;
   logic [31:0] o_dmem_wdata;
   logic [3:0]  o_dmem_be;
   logic        i_dmem_ack;
   logic [31:0] i_dmem_rdata;

   modport master (
      output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be,
      input  i_dmem_ack, i_dmem_rdata
   );

   modport slave (
      input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata, o_dmem_be,
      output i_dmem_ack, i_dmem_rdata
   );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enables and lane-replicated write
// data, load lane extract with sign/zero extension, and misalign detect.
// Ports: addr_lo/data_type/uns/st_data/rdata in; wdata/be/ld_data/misaligned out.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  data_type,
   input  logic        uns,
   input  logic [31:0] st_data,
   input  logic [31:0] rdata,
   output logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] ld_data,
   output logic        misaligned
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      wdata      = '0;
      be         = '0;
      ld_data    = '0;
      misaligned = 1'b0;
      ld_byte    = rdata[{addr_lo, 3'b000} +: 8];
      ld_half    = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      case (data_type)
         DT_BYTE: begin
            be      = 4'b0001 << addr_lo;
            wdata   = {4{st_data[7:0]}};
            ld_data = uns ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         end
         DT_HALF: begin
            misaligned = addr_lo[0];
            be         = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata      = {2{st_data[15:0]}};
            ld_data    = uns ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
         end
         default: begin
            // word, and the unused 2'b11 size encoding
            misaligned = (addr_lo != 2'b00);
            be         = 4'b1111;
            wdata      = st_data;
            ld_data    = rdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: issues one req/ack data-memory access per
// load/store, returns extended load data, stalls the pipe while busy.
// Ports: EX/MEM access fields in; stall, dmem bus (interface), load result and status pulses out.
module mem_stage_lsu
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
)(
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [31:0]  i_alu_dataM,
   input  logic [31:0]  i_rs2_dataHM,
   input  logic [1:0]   i_mem_wrenM,
   input  logic [1:0]   i_data_typeM,
   input  logic         i_unsignedM,
   output logic         o_stall_mem,
   lsu_dmem_if.master   dmem,
   output logic [31:0]  o_ld_dataM,
   output logic         o_ld_validM,
   output logic         o_misalign,
   output logic         o_bus_err
);

   // counter holds completed no-ack REQ cycles, so it tops out at TIMEOUT_CYCLES-1
   localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   lsu_state_e  state_q, state_d;
   logic [CW-1:0] cnt_q;

   logic        access, misaligned, issue;
   logic        go_req, ack_done, timeout;
   logic [31:0] al_wdata, al_ld_data;
   logic [3:0]  al_be;

   logic        req_q, we_q;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  be_q;

   // EX/MEM is frozen by the stall for the whole access, so the live
   // inputs still describe the in-flight instruction when ack arrives.
   lsu_align u_align (
      .addr_lo    (i_alu_dataM[1:0]),
      .data_type  (i_data_typeM),
      .uns        (i_unsignedM),
      .st_data    (i_rs2_dataHM),
      .rdata      (dmem.i_dmem_rdata),
      .wdata      (al_wdata),
      .be         (al_be),
      .ld_data    (al_ld_data),
      .misaligned (misaligned)
   );

   assign access = is_access(i_mem_wrenM);
   assign issue  = access & ~misaligned;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      go_req   = 1'b0;
      ack_done = 1'b0;
      timeout  = 1'b0;
      case (state_q)
         IDLE: begin
            if (issue) begin
               state_d = REQ;
               go_req  = 1'b1;
            end
         end
         REQ: begin
            // ack has priority over a timeout landing in the same cycle
            if (dmem.i_dmem_ack) begin
               state_d  = DONE;
               ack_done = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               timeout = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) cnt_q <= '0;
      else if (state_q == REQ && state_d == REQ) cnt_q <= cnt_q + 1'b1;
      else cnt_q <= '0;
   end

   // bus fields: loaded on issue, cleared when REQ is left
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else if (go_req) begin
         req_q   <= 1'b1;
         we_q    <= (i_mem_wrenM == MEM_STORE);
         addr_q  <= {i_alu_dataM[31:2], 2'b00};
         wdata_q <= (i_mem_wrenM == MEM_STORE) ? al_wdata : 32'h0;
         be_q    <= al_be;
      end else if (ack_done || timeout) begin
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end
   end

   // result registers land in DONE, the cycle MEM/WB samples
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_ld_dataM  <= '0;
         o_ld_validM <= 1'b0;
         o_bus_err   <= 1'b0;
      end else begin
         o_ld_validM <= ack_done & ~we_q;
         o_bus_err   <= timeout;
         if (ack_done && !we_q) o_ld_dataM <= al_ld_data;
         else if (timeout)      o_ld_dataM <= '0;
      end
   end

   assign dmem.o_dmem_req   = req_q;
   assign dmem.o_dmem_we    = we_q;
   assign dmem.o_dmem_addr  = addr_q;
   assign dmem.o_dmem_wdata = wdata_q;
   assign dmem.o_dmem_be    = be_q;

   // gated by reset so stall and misalign drop with the async reset even
   // though the frozen EX/MEM may still present an access
   assign o_stall_mem = i_rst_n & (((state_q == IDLE) & issue) | (state_q == REQ));
   assign o_misalign  = i_rst_n & (state_q == IDLE) & access & misaligned;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed table-driven bench for mem_stage_lsu (TIMEOUT_CYCLES=4).
// Each vector runs one access through IDLE/REQ/DONE with a memory model
// acking after a given number of wait cycles; outputs sampled off-edge.
module tb_mem_stage_lsu;

   logic        clk;
   logic        rst_n;
   logic [31:0] alu_data;
   logic [31:0] rs2_data;
   logic [1:0]  mem_wren;
   logic [1:0]  data_type;
   logic        uns;
   logic        stall;
   logic [31:0] ld_data;
   logic        ld_valid;
   logic        misalign;
   logic        bus_err;

   int checks = 0;
   int errors = 0;

   lsu_dmem_if dmem_if ();

   mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_alu_dataM  (alu_data),
      .i_rs2_dataHM (rs2_data),
      .i_mem_wrenM  (mem_wren),
      .i_data_typeM (data_type),
      .i_unsignedM  (uns),
      .o_stall_mem  (stall),
      .dmem         (dmem_if),
      .o_ld_dataM   (ld_data),
      .o_ld_validM  (ld_valid),
      .o_misalign   (misalign),
      .o_bus_err    (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  kind;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      int          waits;
      bit          ack_en;
      logic        e_we;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [3:0]  e_be;
      int          e_stall;
      int          e_req;
      int          e_ldv;
      logic [31:0] e_ld;
      int          e_mis;
      int          e_err;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Runs one access; called right after a negedge, returns at a negedge.
   task automatic run_vec(input int idx, input vec_t v);
      int stall_cnt = 0, req_cnt = 0, ldv_cnt = 0, mis_cnt = 0, err_cnt = 0;
      bit done = 0, seen_req = 0, unstable = 0, done_nonzero = 0;
      logic        f_we = 0;
      logic [31:0] f_addr = 0, f_wdata = 0, f_ld;
      logic [3:0]  f_be = 0;
      string tag;
      tag = $sformatf("v%0d", idx);
      alu_data  = v.addr;
      rs2_data  = v.wd;
      mem_wren  = v.kind;
      data_type = v.size;
      uns       = v.uns;
      dmem_if.i_dmem_rdata = v.rd;
      f_ld = ld_data;
      for (int c = 0; c < 30 && !done; c++) begin
         #1;
         if (stall)    stall_cnt++;
         if (ld_valid) ldv_cnt++;
         if (misalign) mis_cnt++;
         if (bus_err)  err_cnt++;
         if (dmem_if.o_dmem_req) begin
            req_cnt++;
            if (!seen_req) begin
               seen_req = 1;
               f_we = dmem_if.o_dmem_we;       f_addr = dmem_if.o_dmem_addr;
               f_wdata = dmem_if.o_dmem_wdata; f_be = dmem_if.o_dmem_be;
            end else if (f_we !== dmem_if.o_dmem_we || f_addr !== dmem_if.o_dmem_addr ||
                         f_wdata !== dmem_if.o_dmem_wdata || f_be !== dmem_if.o_dmem_be) begin
               unstable = 1;
            end
            dmem_if.i_dmem_ack = (v.ack_en && req_cnt == v.waits + 1);
         end else begin
            dmem_if.i_dmem_ack = 1'b0;
            if (!stall) begin
               done = 1;
               f_ld = ld_data;
               if (dmem_if.o_dmem_we !== 1'b0 || dmem_if.o_dmem_addr !== 32'h0 ||
                   dmem_if.o_dmem_wdata !== 32'h0 || dmem_if.o_dmem_be !== 4'h0)
                  done_nonzero = 1;
            end
         end
         if (done) begin
            mem_wren = 2'b00;
            dmem_if.i_dmem_ack = 1'b0;
         end
         @(negedge clk);
      end
      if (!done) begin
         errors++;
         checks++;
         $display("FAIL %s_done: access never completed, got stall=%b expected 0", tag, stall);
         mem_wren = 2'b00;
         dmem_if.i_dmem_ack = 1'b0;
         @(negedge clk);
      end
      chk({tag, "_we"},     {31'b0, f_we}, {31'b0, v.e_we});
      chk({tag, "_addr"},   f_addr,        v.e_addr);
      chk({tag, "_wdata"},  f_wdata,       v.e_wdata);
      chk({tag, "_be"},     {28'b0, f_be}, {28'b0, v.e_be});
      chk({tag, "_stall"},  stall_cnt,     v.e_stall);
      chk({tag, "_req"},    req_cnt,       v.e_req);
      chk({tag, "_ldv"},    ldv_cnt,       v.e_ldv);
      chk({tag, "_lddata"}, f_ld,          v.e_ld);
      chk({tag, "_mis"},    mis_cnt,       v.e_mis);
      chk({tag, "_err"},    err_cnt,       v.e_err);
      chk({tag, "_stable"}, {31'b0, unstable},     32'h0);
      chk({tag, "_idlebus"}, {31'b0, done_nonzero}, 32'h0);
   endtask

   initial begin
      //          kind   size   u     addr          wdata         rdata        w  ack we    e_addr        e_wdata       be       st rq ldv e_ld        mis err
      vecs[0]  = '{2'b10, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,       0, 1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 2, 1, 0, 32'h0,       0, 0};
      vecs[1]  = '{2'b01, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_FF12, 3, 1, 1'b0, 32'h0000_0100, 32'h0,       4'b1000, 5, 4, 1, 32'hFFFF_FF80, 0, 0};
      vecs[2]  = '{2'b01, 2'b00, 1'b1, 32'h0000_0103, 32'h0,        32'h80FF_FF12, 3, 1, 1'b0, 32'h0000_0100, 32'h0,       4'b1000, 5, 4, 1, 32'h0000_0080, 0, 0};
      vecs[3]  = '{2'b10, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'h0,       1, 1, 1'b1, 32'h0000_0200, 32'hABCD_ABCD, 4'b1100, 3, 2, 0, 32'h0000_0080, 0, 0};
      vecs[4]  = '{2'b01, 2'b10, 1'b0, 32'h0000_0101, 32'h0,        32'h5555_5555, 0, 1, 1'b0, 32'h0,        32'h0,       4'b0000, 0, 0, 0, 32'h0000_0080, 1, 0};
      vecs[5]  = '{2'b01, 2'b01, 1'b0, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 0, 1, 1'b0, 32'h0000_0100, 32'h0,       4'b1100, 2, 1, 1, 32'hFFFF_8001, 0, 0};
      vecs[6]  = '{2'b01, 2'b00, 1'b1, 32'h0000_0101, 32'h0,        32'h0000_A500, 2, 1, 1'b0, 32'h0000_0100, 32'h0,       4'b0010, 4, 3, 1, 32'h0000_00A5, 0, 0};
      vecs[7]  = '{2'b01, 2'b10, 1'b0, 32'h0000_0104, 32'h0,        32'h1234_5678, 0, 1, 1'b0, 32'h0000_0104, 32'h0,       4'b1111, 2, 1, 1, 32'h1234_5678, 0, 0};
      vecs[8]  = '{2'b10, 2'b00, 1'b0, 32'h0000_0006, 32'h0000_00AB, 32'h0,       0, 1, 1'b1, 32'h0000_0004, 32'hABAB_ABAB, 4'b0100, 2, 1, 0, 32'h1234_5678, 0, 0};
      vecs[9]  = '{2'b10, 2'b01, 1'b0, 32'h0000_0003, 32'h0000_FFFF, 32'h0,       0, 1, 1'b0, 32'h0,        32'h0,       4'b0000, 0, 0, 0, 32'h1234_5678, 1, 0};
      vecs[10] = '{2'b01, 2'b10, 1'b0, 32'h0000_010C, 32'h0,        32'hFFFF_FFFF, 0, 0, 1'b0, 32'h0000_010C, 32'h0,       4'b1111, 5, 4, 0, 32'h0,       0, 1};
      vecs[11] = '{2'b01, 2'b11, 1'b0, 32'h0000_0108, 32'h0,        32'hCAFE_F00D, 1, 1, 1'b0, 32'h0000_0108, 32'h0,       4'b1111, 3, 2, 1, 32'hCAFE_F00D, 0, 0};
      vecs[12] = '{2'b11, 2'b10, 1'b0, 32'h0000_0110, 32'h0,        32'h0,         0, 1, 1'b0, 32'h0,        32'h0,       4'b0000, 0, 0, 0, 32'hCAFE_F00D, 0, 0};

      rst_n = 1'b0;
      alu_data = '0; rs2_data = '0; mem_wren = 2'b00; data_type = 2'b00; uns = 1'b0;
      dmem_if.i_dmem_ack = 1'b0;
      dmem_if.i_dmem_rdata = '0;
      #12;
      chk("rst_req",   {31'b0, dmem_if.o_dmem_req}, 32'h0);
      chk("rst_bus",   dmem_if.o_dmem_addr | dmem_if.o_dmem_wdata | {28'b0, dmem_if.o_dmem_be} | {31'b0, dmem_if.o_dmem_we}, 32'h0);
      chk("rst_ld",    ld_data, 32'h0);
      chk("rst_flags", {28'b0, stall, ld_valid, misalign, bus_err}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

      // reset asserted mid-REQ with an access still presented
      alu_data = 32'h0000_0114; mem_wren = 2'b01; data_type = 2'b10;
      dmem_if.i_dmem_rdata = 32'h7777_7777;
      begin
         bit got_req = 0;
         for (int c = 0; c < 5 && !got_req; c++) begin
            @(negedge clk);
            #1;
            got_req = dmem_if.o_dmem_req;
         end
         chk("mid_req_reached", {31'b0, got_req}, 32'h1);
      end
      #2 rst_n = 1'b0;
      #1;
      chk("arst_req",   {31'b0, dmem_if.o_dmem_req}, 32'h0);
      chk("arst_bus",   dmem_if.o_dmem_addr | {28'b0, dmem_if.o_dmem_be}, 32'h0);
      chk("arst_stall", {31'b0, stall}, 32'h0);
      chk("arst_ld",    ld_data, 32'h0);
      chk("arst_state", {30'b0, dut.state_q}, 32'h0);
      // late ack after reset, with no access presented
      mem_wren = 2'b00;
      dmem_if.i_dmem_ack = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("late_ack_ldv", {31'b0, ld_valid}, 32'h0);
      chk("late_ack_req", {31'b0, dmem_if.o_dmem_req}, 32'h0);
      chk("late_ack_ld",  ld_data, 32'h0);
      chk("late_ack_state", {30'b0, dut.state_q}, 32'h0);
      dmem_if.i_dmem_ack = 1'b0;
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule
